// File: rtl/cdb_pkg.sv
// Shared Common Data Bus definitions used by the broadcaster, reservation
// stations and register file.
package cdb_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    // Tag value that means "no producer"; it never appears on the bus.
    localparam logic [TAG_W-1:0] NO_TAG = '0;

    // One bus beat as seen by the snooping consumers.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    // Occupancy of a per-unit result slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning upward from ptr, wrapping past N-1. Shared with issue-port logic.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW:0]   idx_sum;
    logic [IW-1:0] idx;

    // Scan N positions starting at ptr, wrapping explicitly so non-power-of-2 N works.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx_sum   = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx_sum = {1'b0, ptr} + (IW+1)'(k);
            if (idx_sum >= (IW+1)'(N)) begin
                idx_sum = idx_sum - (IW+1)'(N);
            end
            idx = idx_sum[IW-1:0];
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Producer end of the Common Data Bus: one result slot per functional unit,
// round-robin selection, and a registered single-cycle broadcast.
module cdb_broadcaster #(
    parameter  int NUM_FU = 4,
    parameter  int TAG_W  = cdb_pkg::TAG_W,
    parameter  int DATA_W = cdb_pkg::DATA_W,
    localparam int SRC_W  = $clog2(NUM_FU)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [SRC_W-1:0]         cdb_src,
    output logic                     err_tag0
);

    import cdb_pkg::*;

    logic [NUM_FU-1:0] slot_v;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] store;
    logic [NUM_FU-1:0] tag0_hit;
    logic [TAG_W-1:0]  slot_tag  [NUM_FU];
    logic [DATA_W-1:0] slot_data [NUM_FU];
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_any;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(.N(NUM_FU)) u_arb (
        .req       (slot_v),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
        slot_state_e       state_q;
        slot_state_e       state_d;
        logic [TAG_W-1:0]  tag_q;
        logic [DATA_W-1:0] data_q;
        logic [TAG_W-1:0]  in_tag;
        logic              accept;

        assign in_tag      = fu_tag[i*TAG_W +: TAG_W];
        assign fu_ready[i] = ~slot_v[i] | grant[i];
        assign accept      = fu_valid[i] & fu_ready[i];
        assign store[i]    = accept & (in_tag != TAG_W'(NO_TAG));
        assign tag0_hit[i] = accept & (in_tag == TAG_W'(NO_TAG));
        assign slot_v[i]   = (state_q == SLOT_FULL);
        assign slot_tag[i] = tag_q;
        assign slot_data[i] = data_q;

        // Slot occupancy: fill on a real accept, drain on grant unless refilled the same cycle.
        always_comb begin
            state_d = state_q;
            case (state_q)
                SLOT_EMPTY: if (store[i]) state_d = SLOT_FULL;
                SLOT_FULL:  if (!store[i] && grant[i]) state_d = SLOT_EMPTY;
                default:    state_d = SLOT_EMPTY;
            endcase
        end

        // Slot state register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_q <= SLOT_EMPTY;
            else        state_q <= state_d;
        end

        // Capture the offered tag and data whenever a non-zero tag is accepted.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_q  <= '0;
                data_q <= '0;
            end else if (store[i]) begin
                tag_q  <= in_tag;
                data_q <= fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot grant steers the winning slot onto the bus; zero when nothing is granted.
    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (grant[k]) begin
                sel_tag  = sel_tag  | slot_tag[k];
                sel_data = sel_data | slot_data[k];
            end
        end
    end

    // Round-robin pointer moves just past the winner, wrapping at NUM_FU-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == SRC_W'(NUM_FU-1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    // Registered bus beat and the tag-0 drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            err_tag0  <= 1'b0;
        end else begin
            cdb_valid <= grant_any;
            cdb_tag   <= sel_tag;
            cdb_data  <= sel_data;
            cdb_src   <= grant_any ? grant_idx : '0;
            err_tag0  <= |tag0_hit;
        end
    end

endmodule
